// File: rtl/c432_misr.sv
// 16-bit MISR compactor for c432 responses with IDLE/RUN/DONE session control.
// Define C432_MISR_XMASK_EN to add the resp_mask input for X-blocking of response bits.
module c432_misr #(
  parameter int unsigned PATTERNS = 1024,
  parameter logic [15:0] SEED     = 16'h0000,
  parameter logic [15:0] GOLDEN   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        resp_valid,
  input  logic [6:0]  resp,
`ifdef C432_MISR_XMASK_EN
  input  logic [6:0]  resp_mask,
`endif
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature,
  output logic [31:0] count
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q;
  logic [15:0] sig_q, sig_d;
  logic [31:0] cnt_q, cnt_d;
  logic        busy_q, done_q, pass_q;
  logic [6:0]  resp_eff;
  logic        fb;
  logic        last;

  always_comb begin
`ifdef C432_MISR_XMASK_EN
    resp_eff = resp & ~resp_mask;
`else
    resp_eff = resp;
`endif
    fb    = sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10];
    sig_d = {sig_q[14:0], fb} ^ {9'b0, resp_eff};
    cnt_d = cnt_q + 32'd1;
    last  = (cnt_d == PATTERNS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sig_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          // start wins over resp_valid outside RUN; responses are never taken here.
          if (start) begin
            state_q <= StRun;
            sig_q   <= SEED;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        StRun: begin
          if (resp_valid) begin
            sig_q <= sig_d;
            cnt_q <= cnt_d;
            if (last) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (sig_d == GOLDEN);
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;
  assign count     = cnt_q;

endmodule

// File: tb/tb_c432_misr.sv
// Self-checking bench: several c432_misr configurations share one stimulus stream and are
// checked each cycle against a behavioural session model plus hand-computed literals.
module tb_c432_misr;

`ifdef C432_MISR_XMASK_EN
  localparam int NI = 5;
  localparam int unsigned PAT   [NI] = '{2, 2, 1, 4, 3};
  localparam logic [15:0] SEEDS [NI] = '{16'h0000, 16'h0000, 16'h8000, 16'hACE1, 16'h0000};
  localparam logic [15:0] GOLD  [NI] = '{16'h0002, 16'h0003, 16'h0000, 16'h1234, 16'h0000};
  localparam logic [6:0]  MSK   [NI] = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h7F};
`else
  localparam int NI = 4;
  localparam int unsigned PAT   [NI] = '{2, 2, 1, 4};
  localparam logic [15:0] SEEDS [NI] = '{16'h0000, 16'h0000, 16'h8000, 16'hACE1};
  localparam logic [15:0] GOLD  [NI] = '{16'h0002, 16'h0003, 16'h0000, 16'h1234};
  localparam logic [6:0]  MSK   [NI] = '{7'h00, 7'h00, 7'h00, 7'h00};
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       resp_valid = 1'b0;
  logic [6:0] resp = '0;

  logic        d_busy [NI];
  logic        d_done [NI];
  logic        d_pass [NI];
  logic [15:0] d_sig  [NI];
  logic [31:0] d_cnt  [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    c432_misr #(
      .PATTERNS(PAT[g]),
      .SEED    (SEEDS[g]),
      .GOLDEN  (GOLD[g])
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .resp_valid(resp_valid),
      .resp      (resp),
`ifdef C432_MISR_XMASK_EN
      .resp_mask (MSK[g]),
`endif
      .busy      (d_busy[g]),
      .done      (d_done[g]),
      .pass      (d_pass[g]),
      .signature (d_sig[g]),
      .count     (d_cnt[g])
    );
  end

  // Model: 0 = idle, 1 = running, 2 = finished.
  int          m_st   [NI];
  logic [15:0] m_sig  [NI];
  int unsigned m_cnt  [NI];
  logic        m_pass [NI];

  function automatic logic [15:0] step(input logic [15:0] s, input logic [6:0] r);
    logic fb;
    fb = ^(s & 16'hB400);
    return ((s << 1) | 16'(fb)) ^ 16'(r);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        m_st[i]   <= 0;
        m_sig[i]  <= '0;
        m_cnt[i]  <= 0;
        m_pass[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (m_st[i] != 1) begin
          if (start) begin
            m_st[i]   <= 1;
            m_sig[i]  <= SEEDS[i];
            m_cnt[i]  <= 0;
            m_pass[i] <= 1'b0;
          end
        end else if (resp_valid) begin
          m_sig[i] <= step(m_sig[i], resp & ~MSK[i]);
          m_cnt[i] <= m_cnt[i] + 1;
          if (m_cnt[i] + 1 == PAT[i]) begin
            m_st[i]   <= 2;
            m_pass[i] <= (step(m_sig[i], resp & ~MSK[i]) == GOLD[i]);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  bit run_cmp = 1'b0;

  always @(posedge clk) begin
    #2;
    if (run_cmp) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("i%0d busy", i), 32'(d_busy[i]), 32'(m_st[i] == 1));
        chk($sformatf("i%0d done", i), 32'(d_done[i]), 32'(m_st[i] == 2));
        chk($sformatf("i%0d sig", i), 32'(d_sig[i]), 32'(m_sig[i]));
        chk($sformatf("i%0d count", i), d_cnt[i], m_cnt[i]);
        if (m_st[i] == 2) chk($sformatf("i%0d pass", i), 32'(d_pass[i]), 32'(m_pass[i]));
      end
    end
  end

  // Apply one cycle of inputs just after an edge; returns 1 time unit after the next edge.
  task automatic cyc(input logic s, input logic v, input logic [6:0] r);
    start = s;
    resp_valid = v;
    resp = r;
    @(posedge clk);
    #1;
  endtask

  logic [6:0] vec [4] = '{7'h13, 7'h55, 7'h6C, 7'h01};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset sig", 32'(d_sig[0]), 32'h0);
    chk("reset busy", 32'(d_busy[3]), 32'h0);
    chk("reset done/pass", {30'b0, d_done[0], d_pass[0]}, 32'h0);
    rst_n = 1'b1;
    run_cmp = 1'b1;

    cyc(1'b0, 1'b1, 7'h7F);                         // idle ignores responses
    chk("idle count", d_cnt[0], 32'd0);
    chk("idle busy", 32'(d_busy[0]), 32'h0);

    cyc(1'b1, 1'b1, 7'h7F);                         // start wins over resp_valid
    chk("start busy", 32'(d_busy[0]), 32'h1);
    chk("start sig", 32'(d_sig[0]), 32'h0);
    chk("start seed", 32'(d_sig[2]), 32'h8000);

    cyc(1'b0, 1'b1, 7'h01);
    chk("first sig", 32'(d_sig[0]), 32'h0001);
    cyc(1'b0, 1'b1, 7'h00);
    chk("golden sig", 32'(d_sig[0]), 32'h0002);
    chk("golden done", 32'(d_done[0]), 32'h1);
    chk("golden pass", 32'(d_pass[0]), 32'h1);
    chk("golden count", d_cnt[0], 32'd2);
    chk("bad golden pass", 32'(d_pass[1]), 32'h0);
    chk("bad golden sig", 32'(d_sig[1]), 32'h0002);

    cyc(1'b0, 1'b0, 7'h3C);                         // gap
    cyc(1'b1, 1'b0, 7'h00);                         // restart; inst 3 still running
    chk("run ignores start cnt", d_cnt[3], 32'd2);
    chk("run ignores start busy", 32'(d_busy[3]), 32'h1);
    cyc(1'b0, 1'b1, 7'h00);
    chk("p1 sig", 32'(d_sig[2]), 32'h0001);
    chk("p1 done", 32'(d_done[2]), 32'h1);
`ifdef C432_MISR_XMASK_EN
    chk("mask sig", 32'(d_sig[4]), 32'h0);
    chk("mask pass", {30'b0, d_done[4], d_pass[4]}, 32'h3);
`endif
    cyc(1'b0, 1'b0, 7'h00);
    chk("p4 not done", 32'(d_done[3]), 32'h0);
    cyc(1'b0, 1'b1, 7'h2A);
    chk("p4 done", 32'(d_done[3]), 32'h1);
    chk("p4 count", d_cnt[3], 32'd4);

    // Abort mid-session at count 3, then replay a full session.
    cyc(1'b1, 1'b0, 7'h00);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, vec[k]);
    chk("pre-abort count", d_cnt[3], 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(d_busy[3]), 32'h0);
    chk("abort count", d_cnt[3], 32'd0);
    chk("abort sig", 32'(d_sig[3]), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 7'h11);
    chk("post-abort idle", 32'(d_busy[3]), 32'h0);
    cyc(1'b1, 1'b0, 7'h00);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b1, vec[k]);
      cyc(1'b0, 1'b0, 7'h7F);
    end
    chk("replay done", 32'(d_done[3]), 32'h1);

    // Directed mixed stream across all configurations.
    for (int k = 0; k < 16; k++) begin
      logic [6:0] r;
      r = 7'(k * 37 + 5);
      cyc(k % 5 == 0, k % 3 != 1, r);
    end
    cyc(1'b0, 1'b0, 7'h00);

    run_cmp = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
